pin_entry_controller: RTL and testbench

PIN_ENTRY_CONTROLLER -- requirements
Module: pin_entry_controller

---
 rtl/pin_entry_pkg.sv | 8 +
 rtl/pin_entry_timeout_counter.sv | 16 +
 rtl/pin_entry_controller.sv | 101 ++++++++++
 tb/tb_pin_entry_controller.sv | 117 +++++++++++
 4 files changed

// File: rtl/pin_entry_pkg.sv
// pin_entry_pkg: key codes, FSM state type and PIN width shared by the PIN entry block
package pin_entry_pkg;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] KEY_BACKSPACE = 4'hC;
  localparam int PIN_DIGITS = 4;
  typedef enum logic [1:0] {IDLE, COLLECT, FULL, SEND} state_e;
endpackage

// File: rtl/pin_entry_timeout_counter.sv
// pin_entry_timeout_counter: idle-cycle counter that flags expiry at TIMEOUT_CYCLES-1
module pin_entry_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q;
  // count while enabled; clear has priority and also serves as reset
  always_ff @(posedge clk)
    cnt_q <= clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  assign expired = enable && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/pin_entry_controller.sv
// pin_entry_controller: keypad PIN collector with ready/valid hand-off; BACKSPACE enabled by PIN_ENTRY_BACKSPACE_EN
module pin_entry_controller
  import pin_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] pin_out,
  output logic        pin_valid,
  input  logic        pin_ready,
  output logic [2:0]  digit_count,
  output logic        key_error,
  output logic        entry_timeout
);
  state_e      state_q, state_d;
  logic [15:0] pin_q, pin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, err_q, err_d, tmo_q, tmo_d;
  logic        accept, expired, active;
  assign active = (state_q == COLLECT) || (state_q == FULL);
  pin_entry_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .clear  (!reset_n || accept || !active),
    .enable (active),
    .expired(expired)
  );
  // key decode, hand-off and timeout; accepted keys beat a same-cycle expiry
  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    accept  = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9 && (state_q == IDLE || state_q == COLLECT)) begin
        accept  = 1'b1;
        pin_d   = {pin_q[11:0], key_code};
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'(PIN_DIGITS - 1)) ? FULL : COLLECT;
      end else if (key_code == KEY_ENTER && state_q == FULL) begin
        accept  = 1'b1;
        state_d = SEND;
        valid_d = 1'b1;
      end else if (key_code == KEY_CLEAR && state_q != SEND) begin
        accept  = 1'b1;
        pin_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
`ifdef PIN_ENTRY_BACKSPACE_EN
      else if (key_code == KEY_BACKSPACE && active) begin
        accept  = 1'b1;
        pin_d   = {4'h0, pin_q[15:4]};
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? IDLE : COLLECT;
      end
`endif
      else err_d = 1'b1;
    end
    if (state_q == SEND && valid_q && pin_ready) begin
      state_d = IDLE;
      pin_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end
    if (expired && !accept) begin
      state_d = IDLE;
      pin_d   = '0;
      cnt_d   = '0;
      tmo_d   = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pin_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end
  assign pin_out       = pin_q;
  assign pin_valid     = valid_q;
  assign digit_count   = cnt_q;
  assign key_error     = err_q;
  assign entry_timeout = tmo_q;
endmodule

// File: tb/tb_pin_entry_controller.sv
// tb_pin_entry_controller: table-driven scoreboard bench for pin_entry_controller (TIMEOUT_CYCLES=8)
module tb_pin_entry_controller;
  import pin_entry_pkg::*;
`ifdef PIN_ENTRY_BACKSPACE_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif
  typedef struct {
    logic rst, kv; logic [3:0] kc; logic rdy;
    logic [15:0] pin; logic pv; logic [2:0] cnt; logic err, tmo;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, key_valid = 1'b0, pin_ready = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [15:0] pin_out;
  logic pin_valid, key_error, entry_timeout;
  logic [2:0] digit_count;
  int total = 0, bad = 0, step = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  pin_entry_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .pin_out(pin_out), .pin_valid(pin_valid), .pin_ready(pin_ready),
    .digit_count(digit_count), .key_error(key_error), .entry_timeout(entry_timeout)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input logic rst, kv, input logic [3:0] kc, input logic rdy,
                             input logic [15:0] pin, input logic pv, input logic [2:0] cnt,
                             input logic err, tmo);
    vec_t x;
    x.rst = rst; x.kv = kv; x.kc = kc; x.rdy = rdy;
    x.pin = pin; x.pv = pv; x.cnt = cnt; x.err = err; x.tmo = tmo;
    return x;
  endfunction
  task automatic apply(input vec_t x);
    vec_t e;
    reset_n = ~x.rst; key_valid = x.kv; key_code = x.kc; pin_ready = x.rdy;
    exp_q.push_back(x);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    step++; total++;
    if ({pin_out, pin_valid, digit_count, key_error, entry_timeout} !== {e.pin, e.pv, e.cnt, e.err, e.tmo}) begin
      bad++;
      $display("FAIL step %0d: got pin=%h v=%b cnt=%0d err=%b tmo=%b, want pin=%h v=%b cnt=%0d err=%b tmo=%b",
               step, pin_out, pin_valid, digit_count, key_error, entry_timeout, e.pin, e.pv, e.cnt, e.err, e.tmo);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end
  initial begin
    tbl.push_back(v(1,0,0,1, 16'h0000,0,0,0,0));
    tbl.push_back(v(0,1,8,1, 16'h0008,0,1,0,0));
    tbl.push_back(v(0,1,6,1, 16'h0086,0,2,0,0));
    tbl.push_back(v(0,1,4,1, 16'h0864,0,3,0,0));
    tbl.push_back(v(0,1,2,1, 16'h8642,0,4,0,0));
    tbl.push_back(v(0,1,KEY_ENTER,1, 16'h8642,1,4,0,0));
    tbl.push_back(v(0,0,0,1, 16'h0000,0,0,0,0));
    tbl.push_back(v(0,0,0,1, 16'h0000,0,0,0,0));
    tbl.push_back(v(0,1,1,0, 16'h0001,0,1,0,0));
    tbl.push_back(v(0,1,2,0, 16'h0012,0,2,0,0));
    tbl.push_back(v(0,1,KEY_ENTER,0, 16'h0012,0,2,1,0));
    tbl.push_back(v(0,1,3,0, 16'h0123,0,3,0,0));
    tbl.push_back(v(0,1,4,0, 16'h1234,0,4,0,0));
    tbl.push_back(v(0,1,5,0, 16'h1234,0,4,1,0));
    tbl.push_back(v(0,1,KEY_CLEAR,0, 16'h0000,0,0,0,0));
    tbl.push_back(v(0,1,9,0, 16'h0009,0,1,0,0));
    tbl.push_back(v(0,1,8,0, 16'h0098,0,2,0,0));
    tbl.push_back(v(0,1,KEY_BACKSPACE,0, BS ? 16'h0009 : 16'h0098,0, BS ? 3'd1 : 3'd2, !BS,0));
    tbl.push_back(v(0,1,1,0, BS ? 16'h0091 : 16'h0981,0, BS ? 3'd2 : 3'd3,0,0));
    tbl.push_back(v(0,1,KEY_CLEAR,0, 16'h0000,0,0,0,0));
    tbl.push_back(v(0,1,4'hD,0, 16'h0000,0,0,1,0));
    tbl.push_back(v(0,1,KEY_ENTER,0, 16'h0000,0,0,1,0));
    tbl.push_back(v(0,1,KEY_BACKSPACE,0, 16'h0000,0,0,1,0));
    tbl.push_back(v(0,1,4'hF,0, 16'h0000,0,0,1,0));
    tbl.push_back(v(0,1,1,0, 16'h0001,0,1,0,0));
    tbl.push_back(v(0,1,2,0, 16'h0012,0,2,0,0));
    tbl.push_back(v(0,1,3,0, 16'h0123,0,3,0,0));
    tbl.push_back(v(0,1,4,0, 16'h1234,0,4,0,0));
    tbl.push_back(v(0,1,KEY_ENTER,0, 16'h1234,1,4,0,0));
    tbl.push_back(v(0,0,0,0, 16'h1234,1,4,0,0));
    tbl.push_back(v(0,1,5,0, 16'h1234,1,4,1,0));
    tbl.push_back(v(0,1,KEY_CLEAR,0, 16'h1234,1,4,1,0));
    tbl.push_back(v(0,0,0,0, 16'h1234,1,4,0,0));
    tbl.push_back(v(0,0,0,0, 16'h1234,1,4,0,0));
    tbl.push_back(v(0,0,0,1, 16'h0000,0,0,0,0));
    foreach (tbl[i]) apply(tbl[i]);
    // timeout: key 7 then silence, expiry eight edges after the key
    apply(v(0,1,7,0, 16'h0007,0,1,0,0));
    for (int i = 0; i < 7; i++) apply(v(0,0,0,0, 16'h0007,0,1,0,0));
    apply(v(0,0,0,0, 16'h0000,0,0,0,1));
    apply(v(0,0,0,0, 16'h0000,0,0,0,0));
    // accepted key on the expiry cycle wins
    apply(v(0,1,7,0, 16'h0007,0,1,0,0));
    for (int i = 0; i < 7; i++) apply(v(0,0,0,0, 16'h0007,0,1,0,0));
    apply(v(0,1,3,0, 16'h0073,0,2,0,0));
    apply(v(0,0,0,0, 16'h0073,0,2,0,0));
    apply(v(0,1,KEY_CLEAR,0, 16'h0000,0,0,0,0));
    // rejected key does not restart the counter
    apply(v(0,1,7,0, 16'h0007,0,1,0,0));
    for (int i = 0; i < 3; i++) apply(v(0,0,0,0, 16'h0007,0,1,0,0));
    apply(v(0,1,4'hE,0, 16'h0007,0,1,1,0));
    for (int i = 0; i < 3; i++) apply(v(0,0,0,0, 16'h0007,0,1,0,0));
    apply(v(0,0,0,0, 16'h0000,0,0,0,1));
    // reset while offering a PIN, then a fresh entry
    for (int i = 0; i < 4; i++) apply(v(0,1,9,0, 16'h9999 >> (4 * (3 - i)),0,3'(i + 1),0,0));
    apply(v(0,1,KEY_ENTER,0, 16'h9999,1,4,0,0));
    apply(v(1,0,0,0, 16'h0000,0,0,0,0));
    for (int i = 0; i < 4; i++) apply(v(0,1,4'(4 - i),0, 16'h4321 >> (4 * (3 - i)),0,3'(i + 1),0,0));
    apply(v(0,1,KEY_ENTER,0, 16'h4321,1,4,0,0));
    apply(v(0,0,0,1, 16'h0000,0,0,0,0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
